// File: rtl/keypad_key_register_if.sv
// Keypad key register bus: scanner-side inputs (row drive, column sense,
// key-detect) and the accepted-key outputs used by the display mux.
// The master modport is the producer of keypad samples and consumer of
// digits; the slave modport is the key register itself.
interface keypad_key_register_if;
  logic [3:0] rows;
  logic [3:0] columns;
  logic       enable;
  logic [3:0] new_digit;
  logic [3:0] old_digit;
  logic       digit_valid;
  logic       key_held;

  modport master (
    output rows, columns, enable,
    input  new_digit, old_digit, digit_valid, key_held
  );

  modport slave (
    input  rows, columns, enable,
    output new_digit, old_digit, digit_valid, key_held
  );
endinterface

// File: rtl/keypad_key_register.sv
// Keypad key register: decodes the scanner's row/column pair to a hex key
// code, debounces press and release, accepts one key per press and keeps a
// two-digit history (new_digit / old_digit) for the seven-segment mux.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN -- when defined, a held key
// is re-registered every REPEAT_CYCLES clocks.
module keypad_key_register #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 500000
) (
  input  logic                  clk,
  input  logic                  reset,
  keypad_key_register_if.slave  kp
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int               RPT_W   = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES);
`endif

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_REGISTER = 3'd2,
    ST_HELD     = 3'd3,
    ST_RELEASE  = 3'd4
  } state_t;

  // Returns {code_ok, code}: code_ok only for one-hot rows and a single low column.
  function automatic logic [4:0] decode_key(input logic [3:0] r, input logic [3:0] c);
    logic [1:0] ri;
    logic [1:0] ci;
    logic       rv;
    logic       cv;
    logic [3:0] code;
    rv = 1'b1;
    cv = 1'b1;
    case (r)
      4'b1000: ri = 2'd0;
      4'b0100: ri = 2'd1;
      4'b0010: ri = 2'd2;
      4'b0001: ri = 2'd3;
      default: begin ri = 2'd0; rv = 1'b0; end
    endcase
    case (c)
      4'b0111: ci = 2'd0;
      4'b1011: ci = 2'd1;
      4'b1101: ci = 2'd2;
      4'b1110: ci = 2'd3;
      default: begin ci = 2'd0; cv = 1'b0; end
    endcase
    case ({ri, ci})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      4'd15:   code = 4'hD;
      default: code = 4'h0;
    endcase
    return {rv & cv, code};
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       latched_r;
  logic [3:0]       new_digit_r;
  logic [3:0]       old_digit_r;
  logic             digit_valid_r;
  logic             key_held_r;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [RPT_W-1:0] rep_r;
`endif

  logic [3:0]       code_s;
  logic             code_ok_s;
  logic             match_s;
  logic [CNT_W-1:0] cnt_next_s;

  // Combinational decode, match against the latched key and saturating count.
  always_comb begin
    {code_ok_s, code_s} = decode_key(kp.rows, kp.columns);
    match_s = kp.enable & code_ok_s & (code_s == latched_r);
    if (cnt_r == CNT_MAX) begin
      cnt_next_s = cnt_r;
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
  end

  // Press/release debounce FSM with registered digit history and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_W'(0);
      latched_r     <= 4'h0;
      new_digit_r   <= 4'h0;
      old_digit_r   <= 4'h0;
      digit_valid_r <= 1'b0;
      key_held_r    <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_r         <= RPT_W'(0);
`endif
    end else begin
      digit_valid_r <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      // Repeat counter only survives while sitting in HELD with the key down.
      rep_r         <= RPT_W'(0);
`endif
      case (state_r)
        ST_IDLE: begin
          if (kp.enable && code_ok_s) begin
            latched_r <= code_s;
            cnt_r     <= CNT_W'(1);
            if (DEBOUNCE_CYCLES <= 1) begin
              state_r <= ST_REGISTER;
            end else begin
              state_r <= ST_DEBOUNCE;
            end
          end else begin
            cnt_r <= CNT_W'(0);
          end
        end
        ST_DEBOUNCE: begin
          if (match_s) begin
            cnt_r <= cnt_next_s;
            if (cnt_next_s == CNT_MAX) begin
              state_r <= ST_REGISTER;
            end else begin
              state_r <= ST_DEBOUNCE;
            end
          end else begin
            cnt_r   <= CNT_W'(0);
            state_r <= ST_IDLE;
          end
        end
        ST_REGISTER: begin
          old_digit_r   <= new_digit_r;
          new_digit_r   <= latched_r;
          digit_valid_r <= 1'b1;
          key_held_r    <= 1'b1;
          cnt_r         <= CNT_W'(0);
          state_r       <= ST_HELD;
        end
        ST_HELD: begin
          if (kp.enable) begin
            state_r <= ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rep_r + RPT_W'(1) == RPT_MAX) begin
              old_digit_r   <= new_digit_r;
              new_digit_r   <= latched_r;
              digit_valid_r <= 1'b1;
              rep_r         <= RPT_W'(0);
            end else begin
              rep_r <= rep_r + RPT_W'(1);
            end
`endif
          end else if (DEBOUNCE_CYCLES <= 1) begin
            // A single released sample already satisfies the debounce.
            key_held_r <= 1'b0;
            cnt_r      <= CNT_W'(0);
            state_r    <= ST_IDLE;
          end else begin
            cnt_r   <= CNT_W'(1);
            state_r <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (kp.enable) begin
            cnt_r   <= CNT_W'(0);
            state_r <= ST_HELD;
          end else if (cnt_next_s == CNT_MAX) begin
            key_held_r <= 1'b0;
            cnt_r      <= CNT_W'(0);
            state_r    <= ST_IDLE;
          end else begin
            cnt_r <= cnt_next_s;
          end
        end
        default: begin
          cnt_r      <= CNT_W'(0);
          key_held_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign kp.new_digit   = new_digit_r;
  assign kp.old_digit   = old_digit_r;
  assign kp.digit_valid = digit_valid_r;
  assign kp.key_held    = key_held_r;

endmodule

// File: tb/tb_keypad_key_register.sv
// Testbench for keypad_key_register: directed scenarios plus randomized key
// sessions, every output compared each cycle against a sample-history model.
module tb_keypad_key_register;

  localparam int DEB = 4;
  localparam int RPT = 8;

  logic clk;
  logic reset;
  keypad_key_register_if kp();

  keypad_key_register #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(RPT)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Hex code per (row index * 4 + column index)
  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  // Model: outputs plus counts of consecutive qualifying samples
  int m_new, m_old, m_dv, m_held;
  bit m_inhold, m_pend;
  int m_cand, m_run, m_low, m_rep;
  int obs_pulses, mdl_pulses;

  task automatic check_value(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int key_of(input logic [3:0] r, input logic [3:0] c);
    int ri, ci;
    ri = -1;
    ci = -1;
    if ($countones(r) != 1 || $countones(~c) != 1) return -1;
    for (int i = 0; i < 4; i++) begin
      if (r[3-i]) ri = i;
      if (!c[3-i]) ci = i;
    end
    return keymap[ri*4 + ci];
  endfunction

  task automatic model_reset();
    m_new = 0; m_old = 0; m_dv = 0; m_held = 0;
    m_inhold = 0; m_pend = 0;
    m_cand = -1; m_run = 0; m_low = 0; m_rep = 0;
  endtask

  task automatic model_accept();
    m_old = m_new;
    m_new = m_cand;
    m_dv = 1;
    mdl_pulses++;
  endtask

  // One clock edge of the reference behaviour, from the sampled inputs.
  task automatic model_step(input bit en, input logic [3:0] r, input logic [3:0] c);
    int k;
    k = en ? key_of(r, c) : -1;
    m_dv = 0;
    if (m_pend) begin
      model_accept();
      m_held = 1; m_pend = 0; m_inhold = 1; m_low = 0; m_rep = 0;
    end else if (m_inhold) begin
      if (en) begin
        if (m_low > 0) begin
          m_low = 0;
          m_rep = 0;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          m_rep++;
          if (m_rep >= RPT) begin
            model_accept();
            m_rep = 0;
          end
`endif
        end
      end else begin
        m_rep = 0;
        m_low++;
        if (m_low >= DEB) begin
          m_held = 0; m_inhold = 0; m_cand = -1; m_low = 0;
        end
      end
    end else if (m_cand < 0) begin
      if (k >= 0) begin
        m_cand = k;
        m_run = 1;
        if (m_run >= DEB) m_pend = 1;
      end
    end else if (k == m_cand) begin
      m_run++;
      if (m_run >= DEB) m_pend = 1;
    end else begin
      m_cand = -1;
      m_run = 0;
    end
  endtask

  // Apply inputs at negedge, advance the model at posedge, compare at negedge.
  task automatic drive_cycle(input bit en, input logic [3:0] r, input logic [3:0] c);
    kp.enable = en;
    kp.rows = r;
    kp.columns = c;
    @(posedge clk);
    if (reset) model_reset();
    else model_step(en, r, c);
    @(negedge clk);
    check_value("new_digit", int'(kp.new_digit), m_new);
    check_value("old_digit", int'(kp.old_digit), m_old);
    check_value("digit_valid", int'(kp.digit_valid), m_dv);
    check_value("key_held", int'(kp.key_held), m_held);
    obs_pulses += int'(kp.digit_valid);
  endtask

  int pulse_at, fall_at, snap_new, snap_old, seg_len, sel;
  logic [3:0] r_s, c_s;
  bit en_s;

  initial begin
    obs_pulses = 0;
    mdl_pulses = 0;
    model_reset();
    reset = 1'b1;
    kp.enable = 1'b0;
    kp.rows = 4'b0000;
    kp.columns = 4'b1111;
    drive_cycle(1'b0, 4'b0000, 4'b1111);
    drive_cycle(1'b0, 4'b0000, 4'b1111);
    reset = 1'b0;

    // 1: reset mid-debounce, then a fresh debounce of key 1
    drive_cycle(1'b1, 4'b1000, 4'b0111);
    drive_cycle(1'b1, 4'b1000, 4'b0111);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) drive_cycle(1'b1, 4'b1000, 4'b0111);
    check_value("reset_new", int'(kp.new_digit), 0);
    check_value("reset_held", int'(kp.key_held), 0);
    reset = 1'b0;
    obs_pulses = 0;
    pulse_at = 0;
    for (int i = 1; i <= 8; i++) begin
      drive_cycle(1'b1, 4'b1000, 4'b0111);
      if (kp.digit_valid && pulse_at == 0) pulse_at = i;
    end
    check_value("t1_latency", pulse_at, 1 + DEB);
    check_value("t1_pulses", obs_pulses, 1);
    check_value("t1_new", int'(kp.new_digit), 1);
    check_value("t1_old", int'(kp.old_digit), 0);

    // 2: release, press D, release again and time key_held falling
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 4'b0000, 4'b1111);
    obs_pulses = 0;
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 4'b0001, 4'b1110);
    check_value("t2_pulses", obs_pulses, 1);
    check_value("t2_new", int'(kp.new_digit), 13);
    check_value("t2_old", int'(kp.old_digit), 1);
    fall_at = 0;
    for (int i = 1; i <= 8; i++) begin
      drive_cycle(1'b0, 4'b0000, 4'b1111);
      if (!kp.key_held && fall_at == 0) fall_at = i;
    end
    check_value("t2_release", fall_at, DEB);

    // 3: bouncing contact never qualifies
    obs_pulses = 0;
    for (int i = 0; i < 2; i++) drive_cycle(1'b1, 4'b0100, 4'b1011);
    drive_cycle(1'b0, 4'b0100, 4'b1011);
    for (int i = 0; i < 2; i++) drive_cycle(1'b1, 4'b0100, 4'b1011);
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, 4'b0000, 4'b1111);
    check_value("t3_pulses", obs_pulses, 0);
    check_value("t3_held", int'(kp.key_held), 0);

    // 4: long hold of key 4, column changes mid-hold
    obs_pulses = 0;
    mdl_pulses = 0;
    for (int i = 0; i < 100; i++)
      drive_cycle(1'b1, 4'b0100, (i < 50) ? 4'b0111 : 4'b1011);
    check_value("t4_new", int'(kp.new_digit), 4);
`ifdef KEYPAD_AUTOREPEAT_EN
    check_value("t4_pulses", obs_pulses, mdl_pulses);
`else
    check_value("t4_pulses", obs_pulses, 1);
`endif

    // 5: short enable dropout while held
    obs_pulses = 0;
    mdl_pulses = 0;
    for (int i = 0; i < 2; i++) drive_cycle(1'b0, 4'b0000, 4'b1111);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 4'b0100, 4'b0111);
    check_value("t5_held", int'(kp.key_held), 1);
    check_value("t5_pulses", obs_pulses, mdl_pulses);
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, 4'b0000, 4'b1111);

    // 6: invalid patterns are never accepted
    obs_pulses = 0;
    snap_new = m_new;
    snap_old = m_old;
    for (int i = 0; i < 20; i++) drive_cycle(1'b1, 4'b1000, 4'b0011);
    for (int i = 0; i < 20; i++) drive_cycle(1'b1, 4'b1100, 4'b0111);
    check_value("t6_pulses", obs_pulses, 0);
    check_value("t6_new", int'(kp.new_digit), snap_new);
    check_value("t6_old", int'(kp.old_digit), snap_old);

    // Randomized key sessions with occasional invalid codes and resets
    for (int s = 0; s < 300; s++) begin
      sel = $urandom_range(0, 9);
      r_s = 4'b1000 >> $urandom_range(0, 3);
      c_s = ~(4'b1000 >> $urandom_range(0, 3));
      if (sel == 0) r_s = 4'($urandom_range(0, 15));
      if (sel == 1) c_s = 4'($urandom_range(0, 15));
      en_s = ($urandom_range(0, 3) != 0);
      seg_len = $urandom_range(1, 12);
      if ($urandom_range(0, 59) == 0) reset = 1'b1;
      for (int i = 0; i < seg_len; i++) begin
        drive_cycle(($urandom_range(0, 15) == 0) ? ~en_s : en_s, r_s, c_s);
        reset = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
